serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
- Sequential bit-serial WIDTH-bit subtractor. Computes d = x - y - bi and borrow-out bo, the inverse operation of the team's ripple-carry adder.
- Processes one bit per clock, LSB first, through a single full-subtractor cell.
- Uses valid/ready handshakes on both sides.
- Used where area matters more than latency, and as a checker partner for the adder datapath: (x + y) - y == x.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range >= 2.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operands presented
- in_ready  output  1  block can accept operands
- x  input  WIDTH  minuend
- y  input  WIDTH  subtrahend
- bi  input  1  borrow-in
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- d  output  WIDTH  difference
- bo  output  1  borrow-out; 1 when x < y + bi as unsigned values

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values:
  - state = IDLE
  - in_ready = 1, out_valid = 0
  - d = 0, bo = 0
  - bit counter = 0, internal operand registers = 0
- State machine:
  - IDLE: in_ready = 1. When in_valid && in_ready, latch x, y and bi into internal registers; set counter = 0; go to RUN. Inputs are not required to stay stable after the accept edge.
  - RUN: in_ready = 0, out_valid = 0. Each cycle, with bit i = counter and running borrow b:
    - d[i] <= x[i] ^ y[i] ^ b
    - b <= (~x[i] & y[i]) | (~(x[i] ^ y[i]) & b)
    - counter increments.
    - After the cycle that processes bit WIDTH-1: bo <= final borrow, go to DONE.
  - DONE: out_valid = 1; d and bo held stable. When out_valid && out_ready, go to IDLE; out_valid drops on that edge.
- Latency:
  - out_valid rises exactly WIDTH clocks after the accept edge.
  - Minimum issue interval is WIDTH + 2 cycles: accept, WIDTH compute cycles, output handshake. There is no overlap between transactions.
- d and bo keep the last result through IDLE until the next RUN begins overwriting d.
- Arithmetic is modulo 2^WIDTH with no saturation. bo is the only unsigned underflow indication.
- Counter width is $clog2(WIDTH). The counter never wraps past WIDTH-1 while in RUN.
- Boundary conditions:
  - in_valid asserted during RUN or DONE: ignored; no capture, because in_ready = 0.
  - out_ready held high before out_valid rises: the handshake completes on the first DONE cycle (one cycle in DONE).
  - out_ready held low: the block stays in DONE indefinitely with outputs stable.
  - rst_n asserted mid-RUN or in DONE: immediate abort to reset values; the in-flight result is lost and never presented.

Optional Feature:
- Macro: SERIAL_SUBTRACTOR_OVF_EN
- Defined:
  - Adds output port ovf (1 bit), reset 0.
  - Signed two's-complement overflow, computed from the latched operands at the final RUN cycle: ovf = (x[W-1] != y[W-1]) && (d[W-1] != x[W-1]).
  - ovf is valid and held with out_valid.
- Not defined: no ovf port and no associated logic.

Decomposition:
- Package serial_subtractor_pkg:
  - state_t enum {IDLE, RUN, DONE}
  - localparam function for counter width
- Sub-module full_subtractor (combinational):
  - inputs a, b, bin
  - outputs diff, bout
  - instantiated once and fed the currently selected bit each RUN cycle.

Test Plan:
- x=0x00, y=0x00, bi=0 -> d=0x00, bo=0; out_valid exactly 8 clocks after the accept edge.
- x=0x03, y=0x01, bi=0 -> d=0x02, bo=0. Also x=0x0C, y=0x06, bi=1 -> d=0x05, bo=0.
- x=0x05, y=0x06, bi=0 -> d=0xFF, bo=1. Also x=0x00, y=0x00, bi=1 -> d=0xFF, bo=1 (borrow-in ripples through all bits).
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid -> d and bo stable, in_ready=0.
  - A new in_valid pulse during this window is ignored.
  - After the handshake, the next operands x=0x10, y=0x01 -> d=0x0F.
- Reset mid-RUN: assert rst_n=0 at bit 4 -> all outputs at reset values immediately, out_valid never pulses. After release, the next transaction completes correctly.
- With SERIAL_SUBTRACTOR_OVF_EN:
  - x=0x80, y=0x01 -> d=0x7F, ovf=1.
  - x=0x7F, y=0x01 -> d=0x7E, ovf=0.

Source files
------------

// File: rtl/serial_subtractor_pkg.sv
// +----------------------------------------------------------------------------+
// | serial_subtractor_pkg                                                      |
// | Shared FSM state encoding and counter sizing for serial_subtractor.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int cnt_width(input int w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_full_subtractor.sv
// +----------------------------------------------------------------------------+
// | full_subtractor                                                            |
// | Single-bit combinational cell: diff = a - b - bin, with borrow-out.        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// +----------------------------------------------------------------------------+
// | serial_subtractor                                                          |
// | Bit-serial WIDTH-bit subtractor (d = x - y - bi), LSB first, one bit per   |
// | clock, valid/ready on both sides. Optional signed overflow output enabled  |
// | by defining SERIAL_SUBTRACTOR_OVF_EN.                                      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             bi,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bo
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  ,output logic            ovf
`endif
);

  localparam int            c_cnt_w    = cnt_width(WIDTH);
  localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_x;
  logic [WIDTH-1:0]   r_y;
  logic               r_b;
  logic [WIDTH-1:0]   r_d;
  logic               r_bo;
  logic               w_accept;
  logic               w_last;
  logic               w_diff;
  logic               w_bout;

  assign w_accept = in_valid && in_ready;
  assign w_last   = (r_cnt == c_last_bit);

  full_subtractor u_fs (
    .a    (r_x[r_cnt]),
    .b    (r_y[r_cnt]),
    .bin  (r_b),
    .diff (w_diff),
    .bout (w_bout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = RUN;
      RUN:     if (w_last) w_state_nxt = DONE;
      DONE:    if (out_valid && out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE:    in_ready  = 1'b1;
      DONE:    out_valid = 1'b1;
      default: ;
    endcase
  end

  // Operands are captured on accept so the producer may change x/y right away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_x   <= '0;
      r_y   <= '0;
      r_b   <= 1'b0;
      r_d   <= '0;
      r_bo  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_x   <= x;
            r_y   <= y;
            r_b   <= bi;
            r_cnt <= '0;
          end
        end
        RUN: begin
          r_d[r_cnt] <= w_diff;
          r_b        <= w_bout;
          if (w_last) begin
            r_bo <= w_bout;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign d  = r_d;
  assign bo = r_bo;

`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic r_ovf;

  // On the final bit w_diff is the result MSB, so overflow is known one edge early.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (r_state == RUN && w_last) begin
      r_ovf <= (r_x[WIDTH-1] != r_y[WIDTH-1]) && (w_diff != r_x[WIDTH-1]);
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// +----------------------------------------------------------------------------+
// | tb_serial_subtractor                                                       |
// | Directed-vector scoreboard bench for serial_subtractor (WIDTH = 8).        |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] x;
  logic [7:0] y;
  logic       bi;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] d;
  logic       bo;
`ifdef SERIAL_SUBTRACTOR_OVF_EN
  logic       ovf;
`endif

  typedef struct packed {
    logic [7:0] d;
    logic       bo;
    logic       ovf;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  serial_subtractor #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .y         (y),
    .bi        (bi),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .d         (d),
    .bo        (bo)
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    ,.ovf      (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        mon_e = q.pop_front();
        chk("result_d", {24'd0, d}, {24'd0, mon_e.d});
        chk("result_bo", {31'd0, bo}, {31'd0, mon_e.bo});
`ifdef SERIAL_SUBTRACTOR_OVF_EN
        chk("result_ovf", {31'd0, ovf}, {31'd0, mon_e.ovf});
`endif
      end
    end
  end

  // Called at posedge+1. Returns at posedge+1 after the handshake (out_ready=1)
  // or on the first DONE cycle (out_ready=0).
  task automatic run_txn(input logic [7:0] tx, input logic [7:0] ty, input logic tb,
                         input logic [7:0] ed, input logic ebo, input logic eovf,
                         input string tag);
    int n;
    exp_t e;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    e.d = ed; e.bo = ebo; e.ovf = eovf;
    q.push_back(e);
    x = tx; y = ty; bi = tb; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    x = ~tx; y = ~ty; bi = ~tb;
    n = 0;
    while (out_valid !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, 32'd8);
    if (out_ready) begin
      @(posedge clk); #1;
      chk({tag, "_one_done_cycle"}, {31'd0, out_valid}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   n;
    logic ok;
    rst_n = 1'b0; in_valid = 1'b0; x = 8'h00; y = 8'h00; bi = 1'b0; out_ready = 1'b1;
    #2;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_d", {24'd0, d}, 32'd0);
    chk("rst_bo", {31'd0, bo}, 32'd0);
`ifdef SERIAL_SUBTRACTOR_OVF_EN
    chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_txn(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0, "zero");
    run_txn(8'h03, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0, "3m1");
    run_txn(8'h0C, 8'h06, 1'b1, 8'h05, 1'b0, 1'b0, "Cm6b");
    run_txn(8'h05, 8'h06, 1'b0, 8'hFF, 1'b1, 1'b0, "5m6");
    run_txn(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0, "0m0b");
    run_txn(8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1, "80m1");
    run_txn(8'h7F, 8'h01, 1'b0, 8'h7E, 1'b0, 1'b0, "7Fm1");

    // Backpressure with a stray in_valid pulse inside the stall window.
    out_ready = 1'b0;
    run_txn(8'h20, 8'h05, 1'b0, 8'h1B, 1'b0, 1'b0, "bp");
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_valid = 1'b1; x = 8'h55; y = 8'h11; bi = 1'b0;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (d !== 8'h1B || bo !== 1'b0 || out_valid !== 1'b1 || in_ready !== 1'b0) ok = 1'b0;
    end
    chk("bp_stable", {31'd0, ok}, 32'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_out_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    run_txn(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b0, "after_bp");

    // Abort mid-RUN at bit 4: no result may ever be presented.
    x = 8'h09; y = 8'h03; bi = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_d", {24'd0, d}, 32'd0);
    chk("abort_bo", {31'd0, bo}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) ok = 1'b0;
    end
    chk("abort_no_output", {31'd0, ok}, 32'd1);
    run_txn(8'h0A, 8'h04, 1'b0, 8'h06, 1'b0, 1'b0, "post_abort");

    repeat (3) @(posedge clk);
    #1;
    n = q.size();
    chk("scoreboard_drained", n, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
